fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised successor to the pipeline forwarding unit.
- Tracks in-flight destination tags for EX, MEM and WB internally, instead of taking them from the pipeline registers.
- Produces an independent per-operand forward select for the instruction in EX, plus a multi-cycle load-use stall controlled by a small FSM.
- Sits beside the ID/EX pipeline register; drives the ALU source muxes, PC/IF-ID hold and the ID/EX bubble insert.

Parameters:
- REG_AW, 5, register address width.
- NUM_SRC, 2, source operands per instruction (2..3).
- LOAD_LAT, 1, bubble cycles required between a load in EX and a dependent consumer (1..7).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- issue_valid_i  in  1  instruction in ID requests to enter EX this cycle.
- issue_rd_i  in  REG_AW  destination of the ID instruction.
- issue_regwrite_i  in  1  ID instruction writes the register file.
- issue_memread_i  in  1  ID instruction is a load.
- id_rs_i  in  NUM_SRC*REG_AW  source registers of the ID instruction; operand k occupies bits [k*REG_AW +: REG_AW].
- flush_i  in  1  branch/exception flush of ID and EX.
- stall_o  out  1  hold PC and IF/ID; insert a bubble into ID/EX.
- forward_o  out  NUM_SRC*2  per-operand select for the EX instruction: 00 = register file, 10 = EX/MEM, 01 = MEM/WB.

Behaviour:
- State: tag entries EX, MEM and WB, each holding {valid, rd, regwrite, memread}. EX also holds ex_rs (NUM_SRC addresses). FSM states: IDLE, STALL. Counter cnt is 3 bits.
- Reset (async, rst_i=1):
  - All entries invalid, rd=0, ex_rs=0.
  - FSM in IDLE, cnt=0.
  - stall_o=0; forward_o=0, since all entries are invalid.
- Tags advance every cycle (the unit never stalls MEM/WB):
  - WB<=MEM and MEM<=EX.
  - EX<=issue fields and ex_rs<=id_rs_i when issue_valid_i=1, stall_o=0 and flush_i=0. Otherwise EX<=bubble (valid=0).
- Forwarding (combinational from registered tags), per operand k, evaluated independently for every operand:
  - 10 if MEM.valid & MEM.regwrite & MEM.rd!=0 & MEM.rd==ex_rs[k].
  - Else 01 if the same condition holds on WB.
  - Else 00.
  - MEM always has priority over WB.
  - A load sitting in MEM is never forwarded as 10. This cannot occur when LOAD_LAT>=1 is honoured; it is checked by assertion.
- Hazard condition: hz = issue_valid_i & EX.valid & EX.memread & EX.regwrite & EX.rd!=0 & (EX.rd matches any id_rs operand).
- FSM:
  - IDLE: stall_o = hz & ~flush_i.
    - If that holds and LOAD_LAT>1: go to STALL with cnt<=LOAD_LAT-1.
    - If LOAD_LAT==1: remain in IDLE (single-cycle stall).
  - STALL: stall_o=1; cnt<=cnt-1; return to IDLE when cnt==1.
  - Total stall length is exactly LOAD_LAT cycles.
  - After a stall the load has left EX, so the hazard is not re-raised.
- flush_i:
  - Forces the FSM to IDLE and cnt to 0.
  - stall_o=0 in the same cycle.
  - EX is loaded with a bubble next edge; MEM and WB are unaffected.
  - Flush wins over a simultaneous hazard.
- Reset asserted mid-stall: immediate return to the reset state; no residual stall.
- rd==0 never forwards and never stalls.
- Operands with identical sources both receive the same select.

Optional Feature:
- Macro: FWD_HAZARD_STATS_EN.
- With the macro defined:
  - Add output stall_cnt_o [32] and output fwd_cnt_o [32].
  - stall_cnt_o increments on every cycle with stall_o=1.
  - fwd_cnt_o increments on every cycle in which any forward_o operand is non-zero.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- Without the macro: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Package fwd_pkg holds:
  - FWD_RF=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01.
  - The FSM state encoding IDLE=1'b0, STALL=1'b1.
  - The stage-tag struct/typedef {valid, rd, regwrite, memread}.
- Sub-module fwd_select: the combinational per-operand priority compare. It is instantiated NUM_SRC times via generate.

Test Plan:
- Reset: rst_i pulsed mid-run -> stall_o=0, forward_o=0 immediately; all tags invalid on the next cycle.
- ALU chain: issue add r3 then sub r4,r3,r3 back-to-back -> on the cycle sub is in EX, forward_o={10,10}.
- Double hazard: issue add r2, then add r2, then use r2 -> forward_o for r2 = 10 (MEM wins over WB); with one unrelated instruction between producer and consumer -> 01.
- Load-use: LOAD_LAT=1, lw r5 then add r6,r5,r1 -> stall_o=1 for exactly 1 cycle, then forward_o operand0=01. With LOAD_LAT=3 -> stall_o high for exactly 3 cycles.
- Flush during stall: LOAD_LAT=3, flush_i=1 in the second stall cycle -> stall_o=0 the same cycle, FSM IDLE, EX bubble next cycle.
- Zero register: lw r0 then use r0 -> no stall and forward_o=00. With FWD_HAZARD_STATS_EN defined, stall_cnt_o is unchanged.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared encodings and stage-tag type for the forwarding / load-use hazard unit.
package fwd_pkg;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   // Tags store rd at this fixed width so the struct can live here; REG_AW must not exceed it.
   localparam int TAG_AW = 8;

   typedef logic [TAG_AW-1:0] rd_t;

   typedef enum logic {
      IDLE  = 1'b0,
      STALL = 1'b1
   } state_t;

   typedef struct packed {
      logic valid;
      rd_t  rd;
      logic regwrite;
      logic memread;
   } tag_t;

endpackage

// File: rtl/fwd_select.sv
// Per-operand forward select: MEM/EX result beats WB result, rd of zero never matches.
module fwd_select
   import fwd_pkg::*;
(
   input  tag_t       mem_tag,
   input  tag_t       wb_tag,
   input  rd_t        rs,
   output logic [1:0] sel
);

   logic mem_hit;
   logic wb_hit;
   logic unused_tag;

   assign mem_hit = mem_tag.valid & mem_tag.regwrite & (mem_tag.rd != '0) & (mem_tag.rd == rs);
   assign wb_hit  = wb_tag.valid & wb_tag.regwrite & (wb_tag.rd != '0) & (wb_tag.rd == rs);

   // memread only matters for the load-use check done in the parent
   assign unused_tag = mem_tag.memread ^ wb_tag.memread;

   always_comb begin
      sel = FWD_RF;
      if (mem_hit) begin
         sel = FWD_EXMEM;
      end else if (wb_hit) begin
         sel = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use stall unit with internally tracked EX/MEM/WB destination tags.
// Optional saturating stall/forward event counters when FWD_HAZARD_STATS_EN is defined.
//
// state | meaning
// IDLE  | no stall in progress; stall_o follows the load-use hazard (unless flushed)
// STALL | continuing a multi-cycle load-use stall; cnt counts remaining cycles
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int NUM_SRC  = 2,
   parameter int LOAD_LAT = 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      issue_valid_i,
   input  logic [REG_AW-1:0]         issue_rd_i,
   input  logic                      issue_regwrite_i,
   input  logic                      issue_memread_i,
   input  logic [NUM_SRC*REG_AW-1:0] id_rs_i,
   input  logic                      flush_i,
   output logic                      stall_o,
   output logic [NUM_SRC*2-1:0]      forward_o
`ifdef FWD_HAZARD_STATS_EN
   ,
   output logic [31:0]               stall_cnt_o,
   output logic [31:0]               fwd_cnt_o
`endif
);

   localparam logic [2:0] CNT_INIT = 3'(LOAD_LAT - 1);

   tag_t                      ex_q;
   tag_t                      mem_q;
   tag_t                      wb_q;
   logic [NUM_SRC*REG_AW-1:0] ex_rs_q;
   tag_t                      issue_tag;

   state_t                    state_q;
   state_t                    state_d;
   logic [2:0]                cnt_q;
   logic [2:0]                cnt_d;

   logic [NUM_SRC-1:0]        rs_match;
   logic                      hz;
   logic                      accept;

   assign issue_tag = '{valid:    1'b1,
                        rd:       rd_t'(issue_rd_i),
                        regwrite: issue_regwrite_i,
                        memread:  issue_memread_i};

   assign accept = issue_valid_i & ~stall_o & ~flush_i;

   // MEM and WB never hold; a rejected issue becomes a bubble with cleared sources
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ex_q    <= '0;
         mem_q   <= '0;
         wb_q    <= '0;
         ex_rs_q <= '0;
      end else begin
         wb_q  <= mem_q;
         mem_q <= ex_q;
         if (accept) begin
            ex_q    <= issue_tag;
            ex_rs_q <= id_rs_i;
         end else begin
            ex_q    <= '0;
            ex_rs_q <= '0;
         end
      end
   end

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_op
      assign rs_match[k] = (ex_q.rd == rd_t'(id_rs_i[k*REG_AW +: REG_AW]));

      fwd_select u_sel (
         .mem_tag (mem_q),
         .wb_tag  (wb_q),
         .rs      (rd_t'(ex_rs_q[k*REG_AW +: REG_AW])),
         .sel     (forward_o[2*k +: 2])
      );

      // A load in MEM has no data yet; the stall must have kept its consumer out of EX.
      a_no_load_exmem : assert property (@(posedge clk_i) disable iff (rst_i)
         !(mem_q.memread && (forward_o[2*k +: 2] == FWD_EXMEM)));
   end

   assign hz = issue_valid_i & ex_q.valid & ex_q.memread & ex_q.regwrite
             & (ex_q.rd != '0) & (|rs_match);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall_o = 1'b0;
      if (flush_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               stall_o = hz;
               if (hz && (LOAD_LAT > 1)) begin
                  state_d = STALL;
                  cnt_d   = CNT_INIT;
               end
            end
            STALL: begin
               stall_o = 1'b1;
               cnt_d   = cnt_q - 3'd1;
               if (cnt_q == 3'd1) begin
                  state_d = IDLE;
               end
            end
         endcase
      end
   end

`ifdef FWD_HAZARD_STATS_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] fwd_cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         if (stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if ((|forward_o) && (fwd_cnt_q != '1)) begin
            fwd_cnt_q <= fwd_cnt_q + 32'd1;
         end
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign fwd_cnt_o   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: LOAD_LAT=1 and LOAD_LAT=3 units share one directed instruction stream.
module tb_fwd_hazard_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       issue_valid;
   logic [4:0] issue_rd;
   logic       issue_regwrite;
   logic       issue_memread;
   logic [9:0] id_rs;
   logic       flush;
   logic       stall1;
   logic       stall3;
   logic [3:0] fwd1;
   logic [3:0] fwd3;

`ifdef FWD_HAZARD_STATS_EN
   logic [31:0] scnt1, fcnt1, scnt3, fcnt3;
   logic [31:0] snap1, snap3;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int vec_idx = 0;

   typedef struct packed {
      logic        s1;
      logic [3:0]  f1;
      logic        s3;
      logic [3:0]  f3;
      logic [15:0] idx;
   } exp_t;

   exp_t exp_q[$];

   initial forever #5 clk = ~clk;

   fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1)) u_dut1 (
      .clk_i            (clk),
      .rst_i            (rst),
      .issue_valid_i    (issue_valid),
      .issue_rd_i       (issue_rd),
      .issue_regwrite_i (issue_regwrite),
      .issue_memread_i  (issue_memread),
      .id_rs_i          (id_rs),
      .flush_i          (flush),
      .stall_o          (stall1),
      .forward_o        (fwd1)
`ifdef FWD_HAZARD_STATS_EN
      ,
      .stall_cnt_o      (scnt1),
      .fwd_cnt_o        (fcnt1)
`endif
   );

   fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(3)) u_dut3 (
      .clk_i            (clk),
      .rst_i            (rst),
      .issue_valid_i    (issue_valid),
      .issue_rd_i       (issue_rd),
      .issue_regwrite_i (issue_regwrite),
      .issue_memread_i  (issue_memread),
      .id_rs_i          (id_rs),
      .flush_i          (flush),
      .stall_o          (stall3),
      .forward_o        (fwd3)
`ifdef FWD_HAZARD_STATS_EN
      ,
      .stall_cnt_o      (scnt3),
      .fwd_cnt_o        (fcnt3)
`endif
   );

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s vec %0d: got %0h, expected %0h", name, idx, act, exp);
      end
   endtask

   // v rd rw mr rs0 rs1 flush rst | expected stall/forward for LOAD_LAT=1, then LOAD_LAT=3
   task automatic step(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                       input logic [4:0] rs0, input logic [4:0] rs1, input logic fl, input logic r,
                       input logic s1, input logic [3:0] f1, input logic s3, input logic [3:0] f3);
      @(posedge clk);
      #1;
      rst            = r;
      issue_valid    = v;
      issue_rd       = rd;
      issue_regwrite = rw;
      issue_memread  = mr;
      id_rs          = {rs1, rs0};
      flush          = fl;
      exp_q.push_back(exp_t'{s1: s1, f1: f1, s3: s3, f3: f3, idx: 16'(vec_idx)});
      vec_idx++;
   endtask

   task automatic nop(input logic s1, input logic [3:0] f1, input logic s3, input logic [3:0] f3);
      step(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, s1, f1, s3, f3);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall_lat1", int'(e.idx), 32'(stall1), 32'(e.s1));
            chk("fwd_lat1",   int'(e.idx), 32'(fwd1),   32'(e.f1));
            chk("stall_lat3", int'(e.idx), 32'(stall3), 32'(e.s3));
            chk("fwd_lat3",   int'(e.idx), 32'(fwd3),   32'(e.f3));
         end
      end
   end

   initial begin : stim
      rst = 1'b1; issue_valid = 1'b0; issue_rd = '0; issue_regwrite = 1'b0;
      issue_memread = 1'b0; id_rs = '0; flush = 1'b0;

      step(0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 4'b0000);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 4'b0000);

      // ALU chain: add r3; sub r4,r3,r3
      step(1, 3, 1, 0, 1, 2, 0, 0, 0, 4'b0000, 0, 4'b0000);
      step(1, 4, 1, 0, 3, 3, 0, 0, 0, 4'b0000, 0, 4'b0000);
      nop(0, 4'b1010, 0, 4'b1010);
      nop(0, 4'b0000, 0, 4'b0000);
      nop(0, 4'b0000, 0, 4'b0000);

      // add r2; add r2; use r2 -> MEM wins
      step(1, 2, 1, 0, 1, 1, 0, 0, 0, 4'b0000, 0, 4'b0000);
      step(1, 2, 1, 0, 1, 1, 0, 0, 0, 4'b0000, 0, 4'b0000);
      step(1, 7, 1, 0, 2, 5, 0, 0, 0, 4'b0000, 0, 4'b0000);
      nop(0, 4'b0010, 0, 4'b0010);
      nop(0, 4'b0000, 0, 4'b0000);
      // add r2; add r9; use r2 in operand 1 -> WB
      step(1, 2, 1, 0, 1, 1, 0, 0, 0, 4'b0000, 0, 4'b0000);
      step(1, 9, 1, 0, 1, 1, 0, 0, 0, 4'b0000, 0, 4'b0000);
      step(1, 7, 1, 0, 5, 2, 0, 0, 0, 4'b0000, 0, 4'b0000);
      nop(0, 4'b0100, 0, 4'b0100);
      nop(0, 4'b0000, 0, 4'b0000);
      nop(0, 4'b0000, 0, 4'b0000);

      // lw r5; add r6,r5,r1 held in ID while stalled
      step(1, 5, 1, 1, 1, 1, 0, 0, 0, 4'b0000, 0, 4'b0000);
      step(1, 6, 1, 0, 5, 1, 0, 0, 1, 4'b0000, 1, 4'b0000);
      step(1, 6, 1, 0, 5, 1, 0, 0, 0, 4'b0000, 1, 4'b0000);
      step(1, 6, 1, 0, 5, 1, 0, 0, 0, 4'b0001, 1, 4'b0000);
      step(1, 6, 1, 0, 5, 1, 0, 0, 0, 4'b0000, 0, 4'b0000);
      nop(0, 4'b0000, 0, 4'b0000);
      nop(0, 4'b0000, 0, 4'b0000);
      nop(0, 4'b0000, 0, 4'b0000);
      nop(0, 4'b0000, 0, 4'b0000);

      // flush in the second stall cycle
      step(1, 5, 1, 1, 1, 1, 0, 0, 0, 4'b0000, 0, 4'b0000);
      step(1, 6, 1, 0, 5, 1, 0, 0, 1, 4'b0000, 1, 4'b0000);
      step(1, 6, 1, 0, 5, 1, 1, 0, 0, 4'b0000, 0, 4'b0000);
      step(1, 6, 1, 0, 5, 1, 0, 0, 0, 4'b0000, 0, 4'b0000);
      nop(0, 4'b0000, 0, 4'b0000);
      // flush coincident with the hazard; the load still drains to WB
      step(1, 5, 1, 1, 1, 1, 0, 0, 0, 4'b0000, 0, 4'b0000);
      step(1, 6, 1, 0, 5, 1, 1, 0, 0, 4'b0000, 0, 4'b0000);
      step(1, 6, 1, 0, 5, 1, 0, 0, 0, 4'b0000, 0, 4'b0000);
      nop(0, 4'b0001, 0, 4'b0001);
      nop(0, 4'b0000, 0, 4'b0000);
      nop(0, 4'b0000, 0, 4'b0000);
      nop(0, 4'b0000, 0, 4'b0000);

      // lw r0; use r0
`ifdef FWD_HAZARD_STATS_EN
      snap1 = scnt1;
      snap3 = scnt3;
`endif
      step(1, 0, 1, 1, 1, 1, 0, 0, 0, 4'b0000, 0, 4'b0000);
      step(1, 6, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 4'b0000);
      nop(0, 4'b0000, 0, 4'b0000);
      nop(0, 4'b0000, 0, 4'b0000);
`ifdef FWD_HAZARD_STATS_EN
      chk("stall_cnt_lat1_r0", vec_idx, scnt1, snap1);
      chk("stall_cnt_lat3_r0", vec_idx, scnt3, snap3);
`endif

      // reset during a stall
      step(1, 5, 1, 1, 1, 1, 0, 0, 0, 4'b0000, 0, 4'b0000);
      step(1, 6, 1, 0, 5, 1, 0, 0, 1, 4'b0000, 1, 4'b0000);
      step(1, 6, 1, 0, 5, 1, 0, 1, 0, 4'b0000, 0, 4'b0000);
      step(1, 6, 1, 0, 5, 1, 0, 0, 0, 4'b0000, 0, 4'b0000);
      nop(0, 4'b0000, 0, 4'b0000);

      // add r3; add r8,r1,r3 -> operand 1 only
      step(1, 3, 1, 0, 1, 1, 0, 0, 0, 4'b0000, 0, 4'b0000);
      step(1, 8, 1, 0, 1, 3, 0, 0, 0, 4'b0000, 0, 4'b0000);
      nop(0, 4'b1000, 0, 4'b1000);
      nop(0, 4'b0000, 0, 4'b0000);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", vec_idx, 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
